tx_enqueue: RTL and testbench
=============================

Name: tx_enqueue

Overview:
- Packet-interface front end of the 10GE MAC transmit path, in the clk_156m25 domain.
- Accepts 64-bit packet words from the host, validates framing, pads runt frames to 60 bytes and truncates oversize frames.
- Writes words plus an 8-bit status byte into the TX data FIFO write port, and applies backpressure from the FIFO almost-full flag.

Parameters:
- PAD_ENABLE, 1, 1 = pad frames shorter than 60 bytes; 0 = pass them unchanged.
- MAX_FRAME_WORDS, 1519, maximum words per frame; the first word beyond this triggers truncation. Range 9..65535.

Ports:
- clk_156m25  in  1  core clock; all logic is rising-edge.
- reset_156m25_n  in  1  asynchronous active-low reset.
- pkt_tx_data  in  64  packet word; byte0 = [7:0] = first on wire.
- pkt_tx_val  in  1  word valid.
- pkt_tx_sop  in  1  first word of frame; qualified by val.
- pkt_tx_eop  in  1  last word of frame; qualified by val.
- pkt_tx_mod  in  3  valid bytes in the eop word; 0 = 8.
- pkt_tx_full  out  1  host must not assert val; combinational.
- txdfifo_wdata  out  64  FIFO write data.
- txdfifo_wstatus  out  8  [7]=SOP, [6]=EOP, [5]=ERR, [4:3]=0, [2:0]=mod.
- txdfifo_wen  out  1  FIFO write enable.
- txdfifo_walmost_full  in  1  FIFO almost-full flag.
- stat_tx_drop  out  1  1-cycle pulse: word discarded.
- stat_tx_pad  out  1  1-cycle pulse: padding started.
- stat_tx_trunc  out  1  1-cycle pulse: frame truncated.

Behaviour:
- Reset values: all outputs 0; state IDLE; word counter 0. Reset mid-frame abandons the frame; no EOP is emitted.
- Latency: an accepted word appears on txdfifo_* exactly 1 cycle later. wen, wdata and wstatus are registered.
- Accept rule: a word is accepted when val=1 and pkt_tx_full=0.
  - val while full is discarded and pulses stat_tx_drop; no FIFO write.
- pkt_tx_full = txdfifo_walmost_full | (state==PAD).
- Word counter wcnt: 16 bits, counts accepted words of the current frame; saturates at MAX_FRAME_WORDS+1.
- States:
  - IDLE
    - sop accepted: write the word with SOP=1, wcnt=1, go to PKT. If eop is also set, apply the eop rules below.
    - Non-sop word accepted: discard it, pulse stat_tx_drop, stay in IDLE.
  - PKT
    - Non-sop, non-eop word: write it, wcnt++.
    - eop word: write it with EOP=1 and mod=pkt_tx_mod, go to IDLE (padding rules below apply).
    - sop word (protocol error): write data 0 with EOP=1, ERR=1, mod=0, go to IDLE. The new frame is lost and stat_tx_drop pulses.
    - Word number MAX_FRAME_WORDS+1 accepted without eop: write it with EOP=1, ERR=1, mod=0, pulse stat_tx_trunc.
      - Go to DROP, or to IDLE if the word carried eop.
  - DROP: discard every accepted word, with no stat pulses. eop returns to IDLE; sop+eop on the same word also returns to IDLE. A sop without eop stays in DROP.
  - PAD: while walmost_full=0, write a zero word each cycle and increment wcnt.
    - Pad word 8 is written with EOP=1, mod=4, then go to IDLE.
    - While walmost_full=1, stall with no write.
- Padding (PAD_ENABLE=1): frame bytes = 8*(wcnt-1) + (mod==0 ? 8 : mod), evaluated on the eop word.
  - Bytes >= 60: no padding.
  - Eop word is word 8 and bytes < 60 (mod 1..3): write it with EOP=1, mod=4 and the unused bytes zeroed; no PAD state.
  - Eop word number < 8:
    - Write it with EOP=0, mod=0 and bytes at positions >= mod zeroed (none zeroed if mod=0).
    - Pulse stat_tx_pad and go to PAD.
- Simultaneous sop+eop in IDLE: a one-word frame; padded to 8 words when PAD_ENABLE=1.
- Input mod bits on non-eop words are ignored, and output mod is 0 on those words.

Decomposition:
- Shared package (defines.v) holds:
  - TXSTATUS_SOP=7, TXSTATUS_EOP=6, TXSTATUS_ERR=5, TXSTATUS_MOD=2:0
  - MIN_FRAME_BYTES=60, MIN_FRAME_WORDS=8
  - state encodings IDLE/PKT/DROP/PAD
- The status bit positions are shared with the TX dequeue reader.
- One natural sub-module, tx_byte_mask: combinational; takes mod and produces the 64-bit zeroing mask.

Test Plan:
- 10-word frame (sop word 0, eop word 9, mod=5) with walmost_full=0 -> 10 writes one cycle delayed; status 0x80 first, 0x45 last, 0x00 between; no stat pulses.
- One-word frame (sop+eop, mod=3, data 0x1122334455667788) -> 8 writes:
  - first: wstatus 0x80, wdata 0x0000000000667788
  - words 2-7: wstatus 0, wdata 0
  - last: wstatus 0x44, wdata 0
  - stat_tx_pad pulses once, and pkt_tx_full=1 for 7 cycles.
- 8-word frame with eop mod=2 -> 8 writes, last status 0x44, bytes 2-3 zeroed; no PAD cycles.
- sop at word 4 of an open frame -> 4th write is data 0 with status 0x60; stat_tx_drop pulses; the next words are dropped until the next sop.
- MAX_FRAME_WORDS=16, 20-word frame -> 17 writes, 17th status 0x60; stat_tx_trunc pulses; words 18-20 are not written; the next sop frame is written normally.
- walmost_full=1 for 3 cycles during PAD -> no wen for those cycles; padding resumes after; final EOP word still at wcnt=8; a val during full pulses stat_tx_drop.

Source files
------------

// File: rtl/tx_enqueue_pkg.sv
// Shared definitions for the 10GE MAC transmit enqueue path: status byte
// layout (also decoded by the TX dequeue reader), minimum frame size and
// the enqueue state encoding.
package tx_enqueue_pkg;

   localparam int TXSTATUS_SOP     = 7;
   localparam int TXSTATUS_EOP     = 6;
   localparam int TXSTATUS_ERR     = 5;
   localparam int TXSTATUS_MOD_MSB = 2;
   localparam int TXSTATUS_MOD_LSB = 0;

   localparam int MIN_FRAME_BYTES = 60;
   localparam int MIN_FRAME_WORDS = 8;

   // Valid byte count of the final pad word of a minimum-size frame.
   localparam logic [2:0] PAD_LAST_MOD = 3'(MIN_FRAME_BYTES - 8 * (MIN_FRAME_WORDS - 1));

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PKT  = 2'd1,
      DROP = 2'd2,
      PAD  = 2'd3
   } tx_state_e;

   // Total frame length in bytes given the eop word number and its mod field.
   function automatic logic [31:0] frame_bytes(input logic [16:0] word_num,
                                               input logic [2:0]  mod);
      logic [31:0] last_bytes;
      last_bytes = (mod == 3'd0) ? 32'd8 : {29'd0, mod};
      return (({15'd0, word_num} - 32'd1) * 32'd8) + last_bytes;
   endfunction

   // Assemble a FIFO status byte from its fields.
   function automatic logic [7:0] make_status(input logic       sop,
                                              input logic       eop,
                                              input logic       err,
                                              input logic [2:0] mod);
      logic [7:0] s;
      s = '0;
      s[TXSTATUS_SOP] = sop;
      s[TXSTATUS_EOP] = eop;
      s[TXSTATUS_ERR] = err;
      s[TXSTATUS_MOD_MSB:TXSTATUS_MOD_LSB] = mod;
      return s;
   endfunction

endpackage

// File: rtl/tx_enqueue_if.sv
// Host packet interface plus TX data FIFO write port of the enqueue block.
// The slave modport is the enqueue block; master is its environment.
interface tx_enqueue_if;

   logic [63:0] pkt_tx_data;
   logic        pkt_tx_val;
   logic        pkt_tx_sop;
   logic        pkt_tx_eop;
   logic [2:0]  pkt_tx_mod;
   logic        pkt_tx_full;

   logic [63:0] txdfifo_wdata;
   logic [7:0]  txdfifo_wstatus;
   logic        txdfifo_wen;
   logic        txdfifo_walmost_full;

   modport slave (
      input  pkt_tx_data, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod,
      input  txdfifo_walmost_full,
      output pkt_tx_full,
      output txdfifo_wdata, txdfifo_wstatus, txdfifo_wen
   );

   modport master (
      output pkt_tx_data, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod,
      output txdfifo_walmost_full,
      input  pkt_tx_full,
      input  txdfifo_wdata, txdfifo_wstatus, txdfifo_wen
   );

endinterface

// File: rtl/tx_byte_mask.sv
// Byte keep-mask for a final word: bytes below mod are kept, the rest are
// zeroed. mod of 0 means all eight bytes are valid.
module tx_byte_mask (
   input  logic [2:0]  mod,
   output logic [63:0] mask
);

   // Build the keep-mask one byte lane at a time.
   always_comb begin
      mask = '0;
      for (int i = 0; i < 8; i++) begin
         if (mod == 3'd0 || i < int'(mod)) begin
            mask[i*8 +: 8] = 8'hFF;
         end
      end
   end

endmodule

// File: rtl/tx_enqueue.sv
// 10GE MAC transmit enqueue: validates host framing, pads runt frames to
// the minimum frame size, truncates oversize frames and writes words plus
// a status byte into the TX data FIFO one cycle after acceptance.
module tx_enqueue #(
   parameter bit PAD_ENABLE      = 1'b1,
   parameter int MAX_FRAME_WORDS = 1519
) (
   input  logic        clk_156m25,
   input  logic        reset_156m25_n,
   tx_enqueue_if.slave pkt,
   output logic        stat_tx_drop,
   output logic        stat_tx_pad,
   output logic        stat_tx_trunc
);

   import tx_enqueue_pkg::*;

   localparam logic [16:0] MAX_WORDS = 17'(MAX_FRAME_WORDS);
   localparam logic [15:0] WCNT_SAT  = (MAX_FRAME_WORDS >= 65535) ? 16'hFFFF
                                                                   : 16'(MAX_FRAME_WORDS + 1);

   tx_state_e   state, state_next;
   logic [15:0] wcnt, wcnt_next;

   logic        full, accept;
   logic [16:0] word_num;
   logic [31:0] eop_bytes;
   logic        short_frame, pad_needed, pad_in_place, over_max;
   logic [15:0] pad_num;
   logic        pad_last;
   logic [63:0] keep_mask, eop_wdata;
   logic [7:0]  eop_status;

   logic        wen_d, drop_d, pad_d, trunc_d;
   logic [63:0] wdata_d;
   logic [7:0]  wstatus_d;

   assign full             = pkt.txdfifo_walmost_full | (state == PAD);
   assign pkt.pkt_tx_full  = full;
   assign accept           = pkt.pkt_tx_val & ~full;

   // Number this word would have within its frame; a sop in IDLE is word 1.
   assign word_num     = (state == IDLE) ? 17'd1 : ({1'b0, wcnt} + 17'd1);
   assign eop_bytes    = frame_bytes(word_num, pkt.pkt_tx_mod);
   assign short_frame  = PAD_ENABLE && (eop_bytes < 32'(MIN_FRAME_BYTES));
   assign pad_needed   = short_frame && (word_num < 17'(MIN_FRAME_WORDS));
   assign pad_in_place = short_frame && (word_num == 17'(MIN_FRAME_WORDS));
   assign over_max     = word_num > MAX_WORDS;
   assign pad_num      = wcnt + 16'd1;
   assign pad_last     = pad_num == 16'(MIN_FRAME_WORDS);

   tx_byte_mask u_byte_mask (
      .mod  (pkt.pkt_tx_mod),
      .mask (keep_mask)
   );

   // A short eop word is trimmed to its valid bytes; if padding follows it
   // loses its EOP, otherwise it becomes the minimum-size final word.
   assign eop_wdata  = (pad_needed || pad_in_place) ? (pkt.pkt_tx_data & keep_mask)
                                                    : pkt.pkt_tx_data;
   assign eop_status = pad_needed   ? make_status(1'b0, 1'b0, 1'b0, 3'd0) :
                       pad_in_place ? make_status(1'b0, 1'b1, 1'b0, PAD_LAST_MOD) :
                                      make_status(1'b0, 1'b1, 1'b0, pkt.pkt_tx_mod);

   // State and word counter registers.
   always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
      if (!reset_156m25_n) begin
         state <= IDLE;
         wcnt  <= '0;
      end else begin
         state <= state_next;
         wcnt  <= wcnt_next;
      end
   end

   // Next-state and word counter update from the accepted word.
   always_comb begin
      state_next = state;
      wcnt_next  = wcnt;
      case (state)
         IDLE: begin
            if (accept && pkt.pkt_tx_sop) begin
               wcnt_next = 16'd1;
               if (!pkt.pkt_tx_eop)  state_next = PKT;
               else if (pad_needed)  state_next = PAD;
            end
         end
         PKT: begin
            if (accept) begin
               if (pkt.pkt_tx_sop) begin
                  state_next = IDLE;
               end else if (over_max) begin
                  wcnt_next  = WCNT_SAT;
                  state_next = pkt.pkt_tx_eop ? IDLE : DROP;
               end else begin
                  wcnt_next = word_num[15:0];
                  if (pkt.pkt_tx_eop) state_next = pad_needed ? PAD : IDLE;
               end
            end
         end
         DROP: begin
            if (accept && pkt.pkt_tx_eop) state_next = IDLE;
         end
         PAD: begin
            if (!pkt.txdfifo_walmost_full) begin
               wcnt_next = pad_num;
               if (pad_last) state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // FIFO write and statistics pulses for the current cycle, registered below.
   always_comb begin
      wen_d     = 1'b0;
      wdata_d   = '0;
      wstatus_d = '0;
      drop_d    = pkt.pkt_tx_val & full;
      pad_d     = 1'b0;
      trunc_d   = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (pkt.pkt_tx_sop) begin
                  wen_d     = 1'b1;
                  wdata_d   = pkt.pkt_tx_eop ? eop_wdata : pkt.pkt_tx_data;
                  wstatus_d = make_status(1'b1, 1'b0, 1'b0, 3'd0)
                            | (pkt.pkt_tx_eop ? eop_status : 8'h00);
                  pad_d     = pkt.pkt_tx_eop & pad_needed;
               end else begin
                  drop_d = 1'b1;
               end
            end
         end
         PKT: begin
            if (accept) begin
               wen_d = 1'b1;
               if (pkt.pkt_tx_sop) begin
                  wstatus_d = make_status(1'b0, 1'b1, 1'b1, 3'd0);
                  drop_d    = 1'b1;
               end else if (over_max) begin
                  wdata_d   = pkt.pkt_tx_data;
                  wstatus_d = make_status(1'b0, 1'b1, 1'b1, 3'd0);
                  trunc_d   = 1'b1;
               end else begin
                  wdata_d   = pkt.pkt_tx_eop ? eop_wdata : pkt.pkt_tx_data;
                  wstatus_d = pkt.pkt_tx_eop ? eop_status : 8'h00;
                  pad_d     = pkt.pkt_tx_eop & pad_needed;
               end
            end
         end
         PAD: begin
            if (!pkt.txdfifo_walmost_full) begin
               wen_d     = 1'b1;
               wstatus_d = pad_last ? make_status(1'b0, 1'b1, 1'b0, PAD_LAST_MOD) : 8'h00;
            end
         end
         default: ;
      endcase
   end

   // Registered FIFO write port and statistics outputs.
   always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
      if (!reset_156m25_n) begin
         pkt.txdfifo_wen     <= 1'b0;
         pkt.txdfifo_wdata   <= '0;
         pkt.txdfifo_wstatus <= '0;
         stat_tx_drop        <= 1'b0;
         stat_tx_pad         <= 1'b0;
         stat_tx_trunc       <= 1'b0;
      end else begin
         pkt.txdfifo_wen     <= wen_d;
         pkt.txdfifo_wdata   <= wdata_d;
         pkt.txdfifo_wstatus <= wstatus_d;
         stat_tx_drop        <= drop_d;
         stat_tx_pad         <= pad_d;
         stat_tx_trunc       <= trunc_d;
      end
   end

endmodule

// File: tb/tb_tx_enqueue.sv
// Self-checking bench for tx_enqueue: a frame-level reference model pushes
// expected FIFO writes into a scoreboard queue, and a monitor pops and
// compares them whenever the DUT writes.
module tb_tx_enqueue;

   localparam int MAX_WORDS = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic stat_drop, stat_pad, stat_trunc;

   tx_enqueue_if bus ();

   tx_enqueue #(
      .PAD_ENABLE      (1'b1),
      .MAX_FRAME_WORDS (MAX_WORDS)
   ) dut (
      .clk_156m25     (clk),
      .reset_156m25_n (rst_n),
      .pkt            (bus),
      .stat_tx_drop   (stat_drop),
      .stat_tx_pad    (stat_pad),
      .stat_tx_trunc  (stat_trunc)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] data;
      logic [7:0]  status;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   // Reference model state, at frame level.
   bit   frame_open = 0;
   bit   discarding = 0;
   int   n_words    = 0;
   int   pad_left   = 0;
   int   exp_drop = 0, exp_pad = 0, exp_trunc = 0;
   int   seen_drop = 0, seen_pad = 0, seen_trunc = 0;
   int   af_pct = 0;
   int   full_val_pct = 0;

   // Cycle counter used to verify the one-cycle write latency.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, want %h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   function automatic logic [63:0] keep_bytes(input logic [63:0] d, input int nbytes);
      if (nbytes >= 8) return d;
      return d & ((64'd1 << (8 * nbytes)) - 64'd1);
   endfunction

   task automatic push_write(input logic [63:0] d, input logic [7:0] s);
      exp_t e;
      e.data = d;
      e.status = s;
      e.cyc = cyc + 1;
      exp_q.push_back(e);
   endtask

   // Final word of a frame: pad to 60 bytes (8 words, last holding 4 bytes).
   task automatic model_eop(input logic [63:0] d, input logic [7:0] first_bits,
                            input logic [2:0] mod, input int n);
      int last;
      int bytes;
      last  = (mod == 3'd0) ? 8 : int'(mod);
      bytes = 8 * (n - 1) + last;
      if (bytes >= 60) begin
         push_write(d, first_bits | 8'h40 | {5'd0, mod});
      end else if (n == 8) begin
         push_write(keep_bytes(d, last), first_bits | 8'h44);
      end else begin
         push_write(keep_bytes(d, last), first_bits);
         exp_pad++;
         pad_left = 8 - n;
      end
   endtask

   task automatic model_word(input logic [63:0] d, input logic sop, input logic eop,
                             input logic [2:0] mod);
      if (discarding) begin
         if (eop) discarding = 0;
      end else if (!frame_open) begin
         if (sop) begin
            n_words = 1;
            if (eop) model_eop(d, 8'h80, mod, 1);
            else begin
               frame_open = 1;
               push_write(d, 8'h80);
            end
         end else begin
            exp_drop++;
         end
      end else if (sop) begin
         push_write(64'd0, 8'h60);
         exp_drop++;
         frame_open = 0;
      end else begin
         n_words++;
         if (n_words > MAX_WORDS) begin
            push_write(d, 8'h60);
            exp_trunc++;
            frame_open = 0;
            discarding = !eop;
         end else if (eop) begin
            frame_open = 0;
            model_eop(d, 8'h00, mod, n_words);
         end else begin
            push_write(d, 8'h00);
         end
      end
   endtask

   // Drive one cycle of host inputs and advance the reference model.
   task automatic applyStimulus(input logic val, input logic sop, input logic eop,
                                input logic [2:0] mod, input logic [63:0] d,
                                input bit af, output bit accepted);
      bit model_full;
      @(posedge clk);
      #1;
      bus.pkt_tx_val  = val;
      bus.pkt_tx_sop  = sop;
      bus.pkt_tx_eop  = eop;
      bus.pkt_tx_mod  = mod;
      bus.pkt_tx_data = d;
      bus.txdfifo_walmost_full = af;
      model_full = af || (pad_left > 0);
      #1;
      check("pkt_tx_full", 64'(bus.pkt_tx_full), 64'(model_full));
      accepted = 0;
      if (pad_left > 0 && !af) begin
         push_write(64'd0, (pad_left == 1) ? 8'h44 : 8'h00);
         pad_left--;
      end
      if (val && model_full) begin
         exp_drop++;
      end else if (val) begin
         accepted = 1;
         model_word(d, sop, eop, mod);
      end
   endtask

   task automatic idle_cycle(input bit af);
      bit acc;
      applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, af, acc);
   endtask

   // Offer a word until the model says it was accepted (bounded).
   task automatic send_word(input logic [63:0] d, input logic sop, input logic eop,
                            input logic [2:0] mod);
      bit acc;
      bit af;
      int tries;
      acc = 0;
      tries = 0;
      while (!acc && tries < 300) begin
         af = ($urandom_range(99) < af_pct);
         if ((af || pad_left > 0) && ($urandom_range(99) >= full_val_pct))
            applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, af, acc);
         else
            applyStimulus(1'b1, sop, eop, mod, d, af, acc);
         tries++;
      end
      if (!acc) begin
         checks++;
         errors++;
         $display("[TB] FAIL send_word: not accepted after %0d tries, want accept", tries);
      end
   endtask

   task automatic send_frame(input int len, input logic [2:0] last_mod, input int err_idx);
      for (int i = 0; i < len; i++) begin
         logic [63:0] d;
         logic [2:0]  m;
         d = {$urandom, $urandom};
         m = (i == len - 1) ? last_mod : 3'($urandom_range(7));
         send_word(d, (i == 0) || (i == err_idx), i == len - 1, m);
      end
   endtask

   // Drain outstanding writes, then compare statistics pulse counts.
   task automatic checkOutput(input string tag);
      int guard;
      guard = 0;
      while ((exp_q.size() != 0 || pad_left != 0) && guard < 60) begin
         idle_cycle(1'b0);
         guard++;
      end
      idle_cycle(1'b0);
      idle_cycle(1'b0);
      check({tag, " pending writes"}, 64'(exp_q.size()), 64'd0);
      check({tag, " stat_tx_drop count"}, 64'(seen_drop), 64'(exp_drop));
      check({tag, " stat_tx_pad count"}, 64'(seen_pad), 64'(exp_pad));
      check({tag, " stat_tx_trunc count"}, 64'(seen_trunc), 64'(exp_trunc));
   endtask

   // Monitor: compare every FIFO write with the scoreboard head; count pulses.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.txdfifo_wen) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_write: got data %h status %h, want no write",
                        bus.txdfifo_wdata, bus.txdfifo_wstatus);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("wdata", bus.txdfifo_wdata, e.data);
               check("wstatus", 64'(bus.txdfifo_wstatus), 64'(e.status));
               check("write_cycle", 64'(cyc), 64'(e.cyc));
            end
         end
         if (stat_drop)  seen_drop++;
         if (stat_pad)   seen_pad++;
         if (stat_trunc) seen_trunc++;
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, " wen"},     64'(bus.txdfifo_wen), 64'd0);
      check({tag, " wdata"},   bus.txdfifo_wdata, 64'd0);
      check({tag, " wstatus"}, 64'(bus.txdfifo_wstatus), 64'd0);
      check({tag, " drop"},    64'(stat_drop), 64'd0);
      check({tag, " pad"},     64'(stat_pad), 64'd0);
      check({tag, " trunc"},   64'(stat_trunc), 64'd0);
   endtask

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Main stimulus sequence.
   initial begin
      bit acc;
      bus.pkt_tx_val = 0;
      bus.pkt_tx_sop = 0;
      bus.pkt_tx_eop = 0;
      bus.pkt_tx_mod = 0;
      bus.pkt_tx_data = '0;
      bus.txdfifo_walmost_full = 0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      check("reset pkt_tx_full", 64'(bus.pkt_tx_full), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1;

      $display("[TB] 10-word frame, mod 5");
      send_frame(10, 3'd5, -1);
      checkOutput("frame10");

      $display("[TB] one-word frame padded to 8 words");
      send_word(64'h1122334455667788, 1'b1, 1'b1, 3'd3);
      checkOutput("frame1");

      $display("[TB] 8-word frame, mod 2, padded in place");
      send_frame(8, 3'd2, -1);
      checkOutput("frame8");

      $display("[TB] sop inside an open frame");
      send_frame(6, 3'd0, 3);
      checkOutput("sop_err");

      $display("[TB] 20-word frame truncated, then normal frame");
      send_frame(20, 3'd7, -1);
      send_frame(9, 3'd0, -1);
      checkOutput("trunc");

      $display("[TB] almost-full stall during padding");
      send_word(64'hA5A5A5A5A5A5A5A5, 1'b1, 1'b1, 3'd6);
      idle_cycle(1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 64'hDEAD, 1'b1, acc);
      idle_cycle(1'b1);
      idle_cycle(1'b1);
      checkOutput("pad_stall");

      $display("[TB] reset in the middle of a frame");
      send_word(64'h1, 1'b1, 1'b0, 3'd0);
      send_word(64'h2, 1'b0, 1'b0, 3'd0);
      send_word(64'h3, 1'b0, 1'b0, 3'd0);
      idle_cycle(1'b0);
      @(negedge clk);
      #1;
      rst_n = 0;
      frame_open = 0;
      discarding = 0;
      pad_left = 0;
      #1;
      check_reset_outputs("mid_reset");
      @(posedge clk);
      #1;
      rst_n = 1;
      send_word(64'h4, 1'b0, 1'b1, 3'd0);
      send_frame(12, 3'd1, -1);
      checkOutput("after_reset");

      $display("[TB] randomized frames with backpressure");
      af_pct = 20;
      full_val_pct = 25;
      for (int f = 0; f < 60; f++) begin
         int len;
         int err_idx;
         len = int'($urandom_range(20, 1));
         err_idx = ($urandom_range(9) == 0 && len > 2) ? int'($urandom_range(len - 1, 1)) : -1;
         if ($urandom_range(9) == 0)
            send_word({$urandom, $urandom}, 1'b0, 1'($urandom_range(1)), 3'($urandom_range(7)));
         send_frame(len, 3'($urandom_range(7)), err_idx);
         repeat ($urandom_range(2)) idle_cycle(1'($urandom_range(99) < af_pct));
      end
      af_pct = 0;
      full_val_pct = 0;
      checkOutput("random");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
